// File: rtl/rv32m_pkg.sv
// Shared RV32M definitions: funct3 encodings, FSM states and op-class helper.
package rv32m_pkg;

   localparam int unsigned RV_XLEN = 32;

   typedef enum logic [2:0] {
      F3_MUL    = 3'b000,
      F3_MULH   = 3'b001,
      F3_MULHSU = 3'b010,
      F3_MULHU  = 3'b011,
      F3_DIV    = 3'b100,
      F3_DIVU   = 3'b101,
      F3_REM    = 3'b110,
      F3_REMU   = 3'b111
   } funct3_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_e;

   // The upper funct3 bit separates the divide group from the multiply group.
   function automatic logic is_div(input logic [2:0] f3);
      return f3[2];
   endfunction

endpackage

// File: rtl/muldiv_datapath.sv
// Iterative multiply/divide datapath: one shift-add or restoring-divide step
// per enabled edge on unsigned operand magnitudes.
//   multiply: {r_hi, r_lo} is the 64-bit accumulator, r_lo starts as the
//             multiplier, r_opb holds the multiplicand.
//   divide:   r_hi is the partial remainder, r_lo starts as the dividend and
//             collects quotient bits, r_opb holds the divisor.
module muldiv_datapath
   import rv32m_pkg::*;
#(
   parameter int unsigned XLEN = RV_XLEN
)(
   input  logic            Clock,
   input  logic            nReset,
   input  logic            i_load,
   input  logic            i_step,
   input  logic            i_div,
   input  logic [XLEN-1:0] i_opa,
   input  logic [XLEN-1:0] i_opb,
   output logic [XLEN-1:0] o_hi,
   output logic [XLEN-1:0] o_lo
);

   logic            r_div;
   logic [XLEN-1:0] r_hi;
   logic [XLEN-1:0] r_lo;
   logic [XLEN-1:0] r_opb;

   logic [XLEN:0]   w_sum;
   logic [XLEN:0]   w_shift;
   logic [XLEN:0]   w_diff;

   // Single-step arithmetic: conditional add for multiply, trial subtract for divide.
   always_comb begin
      w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opb} : '0);
      w_shift = {r_hi, r_lo[XLEN-1]};
      // w_shift < 2*divisor, so the 33-bit difference's top bit is a clean borrow flag.
      w_diff  = w_shift - {1'b0, r_opb};
   end

   // Accumulator / remainder registers: load on accept, then advance one step per edge.
   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         r_div <= 1'b0;
         r_hi  <= '0;
         r_lo  <= '0;
         r_opb <= '0;
      end else if (i_load) begin
         r_div <= i_div;
         r_hi  <= '0;
         r_lo  <= i_div ? i_opa : i_opb;
         r_opb <= i_div ? i_opb : i_opa;
      end else if (i_step) begin
         if (r_div) begin
            r_hi <= w_diff[XLEN] ? w_shift[XLEN-1:0] : w_diff[XLEN-1:0];
            r_lo <= {r_lo[XLEN-2:0], ~w_diff[XLEN]};
         end else begin
            r_hi <= w_sum[XLEN:1];
            r_lo <= {w_sum[0], r_lo[XLEN-1:1]};
         end
      end
   end

   assign o_hi = r_hi;
   assign o_lo = r_lo;

endmodule

// File: rtl/muldiv_unit.sv
// RV32M multiply/divide unit: start/busy/done handshake, iteration FSM,
// operand sign handling and the register-file writeback triple.
module muldiv_unit
   import rv32m_pkg::*;
#(
   parameter int unsigned XLEN       = RV_XLEN,
   parameter int unsigned ITERATIONS = XLEN
)(
   input  logic            Clock,
   input  logic            nReset,
   input  logic            start,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] rs1,
   input  logic [XLEN-1:0] rs2,
   input  logic [4:0]      rdIn,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result,
   output logic [4:0]      rdOut,
   output logic            writeRegMem
);

   localparam int unsigned    CW      = $clog2(ITERATIONS);
   localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

   state_e            r_state;
   state_e            w_next_state;
   logic [CW-1:0]     r_count;
   logic              r_busy;
   logic              r_done;
   logic              r_wr;
   logic [XLEN-1:0]   r_result;
   logic [4:0]        r_rd;
   logic [4:0]        r_rdout;
   funct3_e           r_f3;
   logic              r_neg_q;
   logic              r_neg_r;
   logic              r_fast;
   logic [XLEN-1:0]   r_fast_val;

   logic              w_accept;
   logic              w_step;
   logic              w_is_div;
   logic              w_a_signed;
   logic              w_b_signed;
   logic              w_a_neg;
   logic              w_b_neg;
   logic              w_div0;
   logic              w_ovf;
   logic              w_fast;
   logic [XLEN-1:0]   w_a_mag;
   logic [XLEN-1:0]   w_b_mag;
   logic [XLEN-1:0]   w_fast_val;
   logic [XLEN-1:0]   w_hi;
   logic [XLEN-1:0]   w_lo;
   logic [XLEN-1:0]   w_final;
   logic [2*XLEN-1:0] w_prod;

   // Operand signedness, magnitudes and the divide-by-zero / overflow shortcut.
   always_comb begin
      w_is_div = is_div(funct3);
      if (w_is_div) begin
         w_a_signed = ~funct3[0];
         w_b_signed = ~funct3[0];
      end else begin
         w_a_signed = (funct3 != F3_MULHU);
         w_b_signed = (funct3 == F3_MUL) || (funct3 == F3_MULH);
      end
      w_a_neg = w_a_signed & rs1[XLEN-1];
      w_b_neg = w_b_signed & rs2[XLEN-1];
      w_a_mag = w_a_neg ? -rs1 : rs1;
      w_b_mag = w_b_neg ? -rs2 : rs2;
      w_div0  = w_is_div && (rs2 == '0);
      w_ovf   = w_is_div && !funct3[0] && (rs1 == MIN_NEG) && (rs2 == '1);
      w_fast  = w_div0 || w_ovf;
      if (w_div0) begin
         w_fast_val = funct3[1] ? rs1 : '1;
      end else begin
         w_fast_val = funct3[1] ? '0 : MIN_NEG;
      end
   end

   // FSM state register.
   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state and step control; IDLE also waits out the done cycle via r_busy.
   always_comb begin
      w_next_state = r_state;
      w_accept     = 1'b0;
      w_step       = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start && !r_busy) begin
               w_accept     = 1'b1;
               w_next_state = w_fast ? S_DONE : S_CALC;
            end
         end
         S_CALC: begin
            w_step = 1'b1;
            if (r_count == CW'(ITERATIONS - 1)) begin
               w_next_state = S_DONE;
            end
         end
         S_DONE: begin
            w_next_state = S_IDLE;
         end
         default: begin
            w_next_state = S_IDLE;
         end
      endcase
   end

   muldiv_datapath #(
      .XLEN(XLEN)
   ) u_datapath (
      .Clock  (Clock),
      .nReset (nReset),
      .i_load (w_accept && !w_fast),
      .i_step (w_step),
      .i_div  (w_is_div),
      .i_opa  (w_a_mag),
      .i_opb  (w_b_mag),
      .o_hi   (w_hi),
      .o_lo   (w_lo)
   );

   // Sign-corrected final value selected by the captured op.
   always_comb begin
      w_prod  = r_neg_q ? -{w_hi, w_lo} : {w_hi, w_lo};
      w_final = '0;
      if (r_fast) begin
         w_final = r_fast_val;
      end else begin
         case (r_f3)
            F3_MUL:                       w_final = w_prod[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU: w_final = w_prod[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:              w_final = r_neg_q ? -w_lo : w_lo;
            default:                      w_final = r_neg_r ? -w_hi : w_hi;
         endcase
      end
   end

   // Handshake, operation capture, iteration counter and writeback registers.
   // The DONE state commits result/rdOut; done and writeRegMem pulse on the
   // following cycle while busy stays high, so a held start is not re-accepted
   // until busy has been low for one cycle.
   always_ff @(posedge Clock or negedge nReset) begin
      if (!nReset) begin
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_wr       <= 1'b0;
         r_result   <= '0;
         r_rd       <= '0;
         r_rdout    <= '0;
         r_f3       <= F3_MUL;
         r_neg_q    <= 1'b0;
         r_neg_r    <= 1'b0;
         r_fast     <= 1'b0;
         r_fast_val <= '0;
         r_count    <= '0;
      end else begin
         if (w_accept) begin
            r_busy     <= 1'b1;
            r_f3       <= funct3_e'(funct3);
            r_rd       <= rdIn;
            r_neg_q    <= w_a_neg ^ w_b_neg;
            r_neg_r    <= w_a_neg;
            r_fast     <= w_fast;
            r_fast_val <= w_fast_val;
            r_count    <= '0;
         end else if (w_step) begin
            r_count <= r_count + CW'(1);
         end
         if (r_state == S_DONE) begin
            r_result <= w_final;
            r_rdout  <= r_rd;
         end
         r_done <= (r_state == S_DONE);
         r_wr   <= (r_state == S_DONE) && (r_rd != '0);
         if (r_done) begin
            r_busy <= 1'b0;
         end
      end
   end

   assign busy        = r_busy;
   assign done        = r_done;
   assign result      = r_result;
   assign rdOut       = r_rdout;
   assign writeRegMem = r_wr;

endmodule
